// File: rtl/iwdg_pkg.sv
// Shared constants for the independent watchdog: keys, register offsets,
// reset values and the prescaler terminal-count mapping.
package iwdg_pkg;

  localparam logic [15:0] KEY_START  = 16'hCCCC;
  localparam logic [15:0] KEY_RELOAD = 16'hAAAA;
  localparam logic [15:0] KEY_ACCESS = 16'h5555;

  localparam logic [31:0] KR_OFS  = 32'h0;
  localparam logic [31:0] PR_OFS  = 32'h4;
  localparam logic [31:0] RLR_OFS = 32'h8;
  localparam logic [31:0] ST_OFS  = 32'hC;

  localparam logic [11:0] RLR_RST = 12'hFFF;
  localparam logic [2:0]  PR_RST  = 3'd0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_KR,
    SEL_PR,
    SEL_RLR,
    SEL_ST
  } reg_sel_e;

  // Terminal count (divider - 1): 4 << pr, saturating at 256.
  function automatic logic [7:0] div_tc(input logic [2:0] pr);
    logic [7:0] tc;
    case (pr)
      3'd0:    tc = 8'd3;
      3'd1:    tc = 8'd7;
      3'd2:    tc = 8'd15;
      3'd3:    tc = 8'd31;
      3'd4:    tc = 8'd63;
      3'd5:    tc = 8'd127;
      default: tc = 8'd255;
    endcase
    return tc;
  endfunction

endpackage

// File: rtl/iwdg_prescaler.sv
// Watchdog prescaler: free-running 8-bit count that emits a one-cycle tick
// every divider cycles while the watchdog is running.
module iwdg_prescaler
  import iwdg_pkg::*;
(
  input  logic       clk_m2s,
  input  logic       rst_m2s,
  input  logic       running,
  input  logic       clear,
  input  logic [2:0] pr,
  output logic       tick
);

  logic [7:0] cnt;

  // Comparison uses the live PR, so a PR write takes effect immediately.
  assign tick = running & (cnt == div_tc(pr));

  always_ff @(posedge clk_m2s) begin
    if (rst_m2s)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else if (running)
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/iwdg_wb.sv
// Independent watchdog with a Wishbone-classic register slave: KR/PR/RLR/SR,
// 12-bit down-counter and a one-cycle rst_iwdg pulse on expiry.
module iwdg_wb
  import iwdg_pkg::*;
#(
  parameter int          IWDG_KR_SIZE  = 16,
  parameter int          IWDG_PR_SIZE  = 3,
  parameter int          IWDG_RLR_SIZE = 12,
  parameter int          IWDG_ST_SIZE  = 2,
  parameter logic [31:0] BASE_ADR      = 32'h0100_0000
)(
  input  logic                    clk_m2s,
  input  logic                    rst_m2s,
  input  logic [IWDG_KR_SIZE-1:0] dat_m2s,
  input  logic [31:0]             adr_m2s,
  input  logic                    cyc_m2s,
  input  logic                    we_m2s,
  input  logic                    stb_m2s,
  output logic [IWDG_KR_SIZE-1:0] dat_s2m,
  output logic                    ack_s2m,
  output logic                    rst_iwdg
);

  localparam logic [31:0] IWDG_KR_ADR  = BASE_ADR + KR_OFS;
  localparam logic [31:0] IWDG_PR_ADR  = BASE_ADR + PR_OFS;
  localparam logic [31:0] IWDG_RLR_ADR = BASE_ADR + RLR_OFS;
  localparam logic [31:0] IWDG_ST_ADR  = BASE_ADR + ST_OFS;
  localparam logic [IWDG_RLR_SIZE-1:0] CNT_ONE = 1;

  logic                     access, wr, rd;
  reg_sel_e                 sel;
  logic [IWDG_KR_SIZE-1:0]  rdata;
  logic [IWDG_PR_SIZE-1:0]  pr;
  logic [IWDG_RLR_SIZE-1:0] rlr, cnt;
  logic [IWDG_ST_SIZE-1:0]  sr;
  logic                     running, unlocked, tick;
  logic                     wr_kr, key_reload;

  // A register access happens only on the edge that raises ack.
  assign access     = cyc_m2s & stb_m2s & ~ack_s2m;
  assign wr         = access & we_m2s;
  assign rd         = access & ~we_m2s;
  assign wr_kr      = wr & (sel == SEL_KR);
  assign key_reload = wr_kr & (dat_m2s == KEY_RELOAD);

  always_comb begin
    sel = SEL_NONE;
    if      (adr_m2s == IWDG_KR_ADR)  sel = SEL_KR;
    else if (adr_m2s == IWDG_PR_ADR)  sel = SEL_PR;
    else if (adr_m2s == IWDG_RLR_ADR) sel = SEL_RLR;
    else if (adr_m2s == IWDG_ST_ADR)  sel = SEL_ST;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_PR:  rdata[IWDG_PR_SIZE-1:0]  = pr;
      SEL_RLR: rdata[IWDG_RLR_SIZE-1:0] = rlr;
      SEL_ST:  rdata[IWDG_ST_SIZE-1:0]  = sr;
      default: rdata = '0;
    endcase
  end

  iwdg_prescaler u_presc (
    .clk_m2s (clk_m2s),
    .rst_m2s (rst_m2s),
    .running (running),
    .clear   (key_reload),
    .pr      (pr),
    .tick    (tick)
  );

  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      ack_s2m  <= 1'b0;
      dat_s2m  <= '0;
      rst_iwdg <= 1'b0;
      pr       <= PR_RST;
      rlr      <= RLR_RST;
      cnt      <= RLR_RST;
      sr       <= '0;
      running  <= 1'b0;
      unlocked <= 1'b0;
    end else begin
      ack_s2m  <= access;
      rst_iwdg <= tick & (cnt == '0);
      if (rd)
        dat_s2m <= rdata;
      if (wr_kr) begin
        if (dat_m2s == KEY_START)
          running <= 1'b1;
        unlocked <= (dat_m2s == KEY_ACCESS);
      end
      // Tick clears the update flags first so a same-edge write still sets them.
      if (tick)
        sr <= '0;
      if (wr && unlocked && sel == SEL_PR) begin
        pr    <= dat_m2s[IWDG_PR_SIZE-1:0];
        sr[0] <= 1'b1;
      end
      if (wr && unlocked && sel == SEL_RLR) begin
        rlr   <= dat_m2s[IWDG_RLR_SIZE-1:0];
        sr[1] <= 1'b1;
      end
      if (key_reload)
        cnt <= rlr;
      else if (tick)
        cnt <= (cnt != '0) ? cnt - CNT_ONE : rlr;
    end
  end

endmodule

// File: tb/tb_iwdg_wb.sv
// Directed self-checking bench for iwdg_wb: register access, prescaled
// countdown, reload/lock rules, expiry pulse timing and bus handshake.
module tb_iwdg_wb;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] A_KR  = BASE + 32'h0;
  localparam logic [31:0] A_PR  = BASE + 32'h4;
  localparam logic [31:0] A_RLR = BASE + 32'h8;
  localparam logic [31:0] A_ST  = BASE + 32'hC;
  localparam logic [31:0] A_BAD = BASE + 32'h10;

  logic        clk_m2s, rst_m2s, cyc_m2s, we_m2s, stb_m2s;
  logic [15:0] dat_m2s, dat_s2m;
  logic [31:0] adr_m2s;
  logic        ack_s2m, rst_iwdg;

  int unsigned errs, checks;

  iwdg_wb #(.BASE_ADR(BASE)) dut (
    .clk_m2s  (clk_m2s),
    .rst_m2s  (rst_m2s),
    .dat_m2s  (dat_m2s),
    .adr_m2s  (adr_m2s),
    .cyc_m2s  (cyc_m2s),
    .we_m2s   (we_m2s),
    .stb_m2s  (stb_m2s),
    .dat_s2m  (dat_s2m),
    .ack_s2m  (ack_s2m),
    .rst_iwdg (rst_iwdg)
  );

  initial clk_m2s = 1'b0;
  always #5 clk_m2s = ~clk_m2s;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One access: the access edge is the first posedge; returns #1 after the
  // following edge so the next call never lands on an ack-high cycle.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [15:0] dat);
    @(negedge clk_m2s);
    cyc_m2s = 1'b1; stb_m2s = 1'b1; we_m2s = we; adr_m2s = adr; dat_m2s = dat;
    @(posedge clk_m2s); #1;
    chk("ack", {31'b0, ack_s2m}, 32'd1);
    cyc_m2s = 1'b0; stb_m2s = 1'b0; we_m2s = 1'b0;
    @(posedge clk_m2s); #1;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [15:0] dat);
    bus(1'b1, adr, dat);
  endtask

  task automatic rd(input string tag, input logic [31:0] adr, input logic [15:0] exp);
    bus(1'b0, adr, 16'h0);
    chk(tag, {16'b0, dat_s2m}, {16'b0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk_m2s);
    rst_m2s = 1'b1;
    @(posedge clk_m2s); #1;
    chk("rst_cnt", {20'b0, dut.cnt}, 32'hFFF);
    chk("rst_ack", {31'b0, ack_s2m}, 32'd0);
    chk("rst_dat", {16'b0, dat_s2m}, 32'd0);
    chk("rst_iwdg", {31'b0, rst_iwdg}, 32'd0);
    @(negedge clk_m2s);
    rst_m2s = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    errs = 0; checks = 0;
    rst_m2s = 1'b1; cyc_m2s = 1'b0; stb_m2s = 1'b0; we_m2s = 1'b0;
    adr_m2s = '0; dat_m2s = '0;
    repeat (2) @(posedge clk_m2s);
    do_reset();

    // Reset values over the bus
    rd("rlr_rst", A_RLR, 16'h0FFF);
    rd("pr_rst", A_PR, 16'h0000);
    rd("kr_read", A_KR, 16'h0000);

    // Start with PR=0: tick every 4 cycles; access edge S, tasks return at S+1
    wr(A_KR, 16'hCCCC);
    repeat (2) @(posedge clk_m2s); #1;
    chk("cnt_s3", {20'b0, dut.cnt}, 32'hFFF);
    @(posedge clk_m2s); #1;
    chk("cnt_s4", {20'b0, dut.cnt}, 32'hFFE);
    repeat (4) @(posedge clk_m2s); #1;
    chk("cnt_s8", {20'b0, dut.cnt}, 32'hFFD);
    wr(A_KR, 16'hAAAA);                 // reload at S+9, prescaler cleared
    chk("reload", {20'b0, dut.cnt}, 32'hFFF);
    repeat (2) @(posedge clk_m2s); #1;
    chk("clr_s12", {20'b0, dut.cnt}, 32'hFFF);
    @(posedge clk_m2s); #1;
    chk("clr_s13", {20'b0, dut.cnt}, 32'hFFE);

    // Mid-run reset stops the watchdog
    do_reset();
    repeat (10) @(posedge clk_m2s); #1;
    chk("stopped", {20'b0, dut.cnt}, 32'hFFF);

    // Locked writes ignored; unlock then PR/RLR update and status flags
    wr(A_RLR, 16'h0001);
    rd("rlr_locked", A_RLR, 16'h0FFF);
    wr(A_KR, 16'h5555);
    wr(A_RLR, 16'h0001);
    wr(A_PR, 16'h0001);
    rd("rlr_new", A_RLR, 16'h0001);
    rd("pr_new", A_PR, 16'h0001);
    rd("sr_set", A_ST, 16'h0003);
    wr(A_KR, 16'hCCCC);                 // start at S, PR=1 -> first tick S+8
    rd("sr_hold", A_ST, 16'h0003);      // returns at S+3
    repeat (4) @(posedge clk_m2s); #1;
    chk("pr1_s7", {20'b0, dut.cnt}, 32'hFFF);
    @(posedge clk_m2s); #1;
    chk("pr1_s8", {20'b0, dut.cnt}, 32'hFFE);
    rd("sr_clr", A_ST, 16'h0000);

    // Any non-0x5555 KR write relocks
    do_reset();
    wr(A_KR, 16'h5555);
    wr(A_KR, 16'h1234);
    wr(A_RLR, 16'h0005);
    rd("relock", A_RLR, 16'h0FFF);

    // RLR=1, PR=0: expiry pulse 8 cycles after start, then every 8
    do_reset();
    wr(A_KR, 16'h5555);
    wr(A_RLR, 16'h0001);
    wr(A_KR, 16'hAAAA);
    chk("cnt_rlr1", {20'b0, dut.cnt}, 32'h1);
    wr(A_KR, 16'hCCCC);                 // start at S, returns at S+1
    for (int k = 2; k <= 17; k++) begin
      @(posedge clk_m2s); #1;
      chk($sformatf("wdg_k%0d", k), {31'b0, rst_iwdg}, {31'b0, (k == 8 || k == 16)});
      if (k == 4) chk("cnt_zero", {20'b0, dut.cnt}, 32'h0);
    end

    // Reload on a tick edge (S+20): reload wins, next pulse at S+28
    repeat (2) @(posedge clk_m2s);
    wr(A_KR, 16'hAAAA);
    chk("rel_tick", {20'b0, dut.cnt}, 32'h1);
    for (int k = 22; k <= 28; k++) begin
      @(posedge clk_m2s); #1;
      chk($sformatf("rel_k%0d", k), {31'b0, rst_iwdg}, {31'b0, (k == 28)});
    end

    // Held request: ack alternates; unmapped write has no effect
    do_reset();
    @(negedge clk_m2s);
    cyc_m2s = 1'b1; stb_m2s = 1'b1; we_m2s = 1'b1; adr_m2s = A_BAD; dat_m2s = 16'hCCCC;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_m2s); #1;
      chk($sformatf("ack_pat%0d", i), {31'b0, ack_s2m}, {31'b0, (i % 2 == 0)});
    end
    cyc_m2s = 1'b0; stb_m2s = 1'b0; we_m2s = 1'b0;
    repeat (8) @(posedge clk_m2s); #1;
    chk("unmap_wr", {20'b0, dut.cnt}, 32'hFFF);
    rd("rlr_keep", A_RLR, 16'h0FFF);
    rd("unmap_rd", A_BAD, 16'h0000);
    rd("sr_zero", A_ST, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/iwdg_wb.md
Name: iwdg_wb

Overview:
- Independent watchdog, modelled on the STM32 IWDG, with a Wishbone-classic slave register interface.
- A 12-bit down-counter is clocked through a programmable prescaler. When the counter expires, the block pulses a watchdog reset.
- Key register (KR) commands: start, reload, and unlock of the PR/RLR registers.
- Sits on the peripheral bus; rst_iwdg feeds the system reset controller.

Parameters:
- IWDG_KR_SIZE, 16, KR width and data bus width.
- IWDG_PR_SIZE, 3, prescaler register width.
- IWDG_RLR_SIZE, 12, reload register width and counter width.
- IWDG_ST_SIZE, 2, status register width.
- BASE_ADR, 32'h0100_0000, block base address.
- IWDG_KR_ADR, BASE_ADR+0x0, key register.
- IWDG_PR_ADR, BASE_ADR+0x4, prescaler register.
- IWDG_RLR_ADR, BASE_ADR+0x8, reload register.
- IWDG_ST_ADR, BASE_ADR+0xC, status register.

Ports:
- clk_m2s  in  1  single clock for bus and watchdog logic.
- rst_m2s  in  1  synchronous, active-high reset.
- dat_m2s  in  16  write data.
- adr_m2s  in  32  byte address.
- cyc_m2s  in  1  bus cycle valid.
- we_m2s  in  1  1 = write, 0 = read.
- stb_m2s  in  1  strobe.
- dat_s2m  out  16  read data, registered.
- ack_s2m  out  1  acknowledge, one-cycle pulse.
- rst_iwdg  out  1  watchdog reset, one-cycle pulse.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_m2s, rst_m2s).
- Reset values: ack_s2m 0, dat_s2m 0, rst_iwdg 0, PR 0, RLR 0xFFF, counter 0xFFF, running 0, unlocked 0, SR 0, prescaler count 0.

Bus handshake:
- At each edge: ack_s2m <= cyc_m2s & stb_m2s & ~ack_s2m. Back-to-back requests therefore see ack high, low, high, …
- A register access executes only on the edge that sets ack, so there is exactly one write per acked cycle.
- Read data is latched into dat_s2m on that same edge.
- Unmapped address: still acked; reads return 0; writes have no effect.

Reads:
- KR returns 0.
- PR, RLR and SR return their values zero-extended.

KR writes (full 16 bits compared):
- 0xCCCC: set running (sticky until rst_m2s); counter is not reloaded.
- 0xAAAA: counter <= RLR, and the prescaler count is cleared.
- 0x5555: unlocked <= 1.
- Any KR write other than 0x5555: unlocked <= 0.

PR/RLR writes:
- Ignored unless unlocked.
- PR takes dat_m2s[2:0]; RLR takes dat_m2s[11:0].
- SR bit0 (PVU) is set on an accepted PR write; SR bit1 (RVU) is set on an accepted RLR write. Both clear at the next prescaler tick.
- SR is read-only.

Prescaler:
- Divider = 4 << PR for PR 0..5; 256 for PR 6 and 7.
- An 8-bit count runs only while running. A tick fires when count == divider-1, then count returns to 0.
- A PR change is used from the next count comparison.

Counter:
- On a tick, if counter != 0, counter decrements.
- On a tick with counter == 0: rst_iwdg = 1 for one cycle, counter <= RLR, and the watchdog keeps running.

Boundary conditions:
- A 0xAAAA reload on the same edge as a tick: reload wins and no decrement occurs.
- RLR = 0: a reset pulse on every tick.
- rst_m2s mid-operation: every register returns to its reset value, including running.
- Counter arithmetic is unsigned 12-bit; no wrap below 0.

Decomposition:
- Package iwdg_pkg holds:
  - key constants KEY_START 16'hCCCC, KEY_RELOAD 16'hAAAA, KEY_ACCESS 16'h5555;
  - register offsets 0x0/0x4/0x8/0xC;
  - reset constants RLR_RST 12'hFFF, PR_RST 3'd0;
  - a divider function mapping PR to its terminal count.
- One sub-module, iwdg_prescaler: running, PR and clear in; tick out.

Test Plan:
- Reset, then read RLR at 0x0100_0008 -> ack one cycle later, dat_s2m = 0x0FFF. Read PR -> 0x0000.
- Write KR=0xCCCC with PR=0 -> first tick 4 cycles later; counter decrements every 4 cycles from 0xFFF. KR=0xAAAA then restores 0xFFF.
- Without unlock, write RLR=0x001 -> read back 0x0FFF. Write KR=0x5555, then RLR=0x001 and PR=1 -> read back 0x0001 and 0x0001; SR shows RVU/PVU until the next tick.
- Unlock, write KR=0x1234, then RLR=0x005 -> write ignored, RLR unchanged.
- RLR=1, PR=0, KR=0xAAAA then 0xCCCC -> counter reaches 0 after 4 cycles; rst_iwdg pulses one cycle 8 cycles after start and repeats every 8 cycles.
- Hold cyc/stb high 4 cycles on a write -> ack pattern 1,0,1,0; write to an unmapped address is acked and has no register effect.
